// File: rtl/cmp_pkg.sv
// Shared definitions for the chunked magnitude comparator: FSM state encoding
// and the {eq, greater, lesser} result-flag ordering.
package cmp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } cmp_state_e;

    typedef struct packed {
        logic eq;
        logic greater;
        logic lesser;
    } cmp_flags_t;

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice.
module cmp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    output logic             eq_o,
    output logic             gt_o,
    output logic             lt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/chunked_comparator.sv
// Multi-cycle magnitude comparator: walks the operands CHUNK bits per clock,
// MSB chunk first, and stops at the first differing chunk.
module chunked_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    input  logic                               signed_mode,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               eq,
    output logic                               greater,
    output logic                               lesser,
    output logic [$clog2(WIDTH/CHUNK+1)-1:0]   cycles
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CW     = $clog2(NCHUNK + 1);

    cmp_state_e         state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               sgn_q, sgn_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [CW-1:0]      cyc_q, cyc_d;
    cmp_flags_t         flags_q, flags_d;

    logic [WIDTH-1:0]   a_adj, b_adj;
    logic [CHUNK-1:0]   a_chunk, b_chunk;
    logic               c_eq, c_gt, c_lt;
    logic               load;

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign load      = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign eq        = flags_q.eq;
    assign greater   = flags_q.greater;
    assign lesser    = flags_q.lesser;
    assign cycles    = cyc_q;

    // Flipping the top bit maps two's-complement order onto unsigned order.
    always_comb begin
        a_adj            = a_q;
        b_adj            = b_q;
        a_adj[WIDTH-1]   = a_q[WIDTH-1] ^ sgn_q;
        b_adj[WIDTH-1]   = b_q[WIDTH-1] ^ sgn_q;
        a_chunk          = a_adj[int'(idx_q)*CHUNK +: CHUNK];
        b_chunk          = b_adj[int'(idx_q)*CHUNK +: CHUNK];
    end

    cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a_i  (a_chunk),
        .b_i  (b_chunk),
        .eq_o (c_eq),
        .gt_o (c_gt),
        .lt_o (c_lt)
    );

    // Next-state, operand capture and result update.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cyc_d   = cyc_q;
        flags_d = flags_q;
        a_d     = load ? a : a_q;
        b_d     = load ? b : b_q;
        sgn_d   = load ? signed_mode : sgn_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = RUN;
                    idx_d   = IDXW'(NCHUNK - 1);
                    cyc_d   = {CW{1'b0}};
                    flags_d = 3'b000;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                cyc_d = cyc_q + CW'(1);
                if (!c_eq) begin
                    flags_d = '{eq: 1'b0, greater: c_gt, lesser: c_lt};
                    state_d = DONE;
                end else if (idx_q == IDXW'(0)) begin
                    flags_d = '{eq: 1'b1, greater: 1'b0, lesser: 1'b0};
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDXW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    // A waiting producer is taken on the same edge: no idle bubble.
                    state_d = load ? RUN : IDLE;
                    idx_d   = IDXW'(NCHUNK - 1);
                    cyc_d   = {CW{1'b0}};
                    flags_d = 3'b000;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = IDXW'(NCHUNK - 1);
                cyc_d   = {CW{1'b0}};
                flags_d = 3'b000;
            end
        endcase
    end

    // State, operand, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sgn_q   <= 1'b0;
            idx_q   <= IDXW'(NCHUNK - 1);
            cyc_q   <= {CW{1'b0}};
            flags_q <= 3'b000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            cyc_q   <= cyc_d;
            flags_q <= flags_d;
        end
    end

endmodule

// File: tb/tb_chunked_comparator.sv
// Scoreboard bench for chunked_comparator (16/4 instance plus a 4/4 instance).
module tb_chunked_comparator;

    localparam int W   = 16;
    localparam int C   = 4;
    localparam int N   = W / C;
    localparam int CWD = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready, signed_mode, out_valid, out_ready;
    logic [W-1:0]   a, b;
    logic           eq, greater, lesser;
    logic [CWD-1:0] cycles;

    logic           in_valid4, in_ready4, signed_mode4, out_valid4;
    logic [3:0]     a4, b4;
    logic           eq4, greater4, lesser4;
    logic [0:0]     cycles4;

    always #5 clk = ~clk;

    chunked_comparator #(.WIDTH(W), .CHUNK(C)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
        .out_ready(out_ready), .eq(eq), .greater(greater), .lesser(lesser),
        .cycles(cycles)
    );

    chunked_comparator #(.WIDTH(4), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .signed_mode(signed_mode4), .out_valid(out_valid4),
        .out_ready(1'b1), .eq(eq4), .greater(greater4), .lesser(lesser4),
        .cycles(cycles4)
    );

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   cyc;
        int   acc_edge;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          edge_cnt = 0;
    logic        rand_ready = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_taken = 1'b0;
    logic [31:0] held;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, expv, $time);
        end
    endtask

    // Reference: plain integer compare; chunks examined = chunks down to the highest differing bit.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        exp_t r;
        logic [W-1:0] diff;
        int p;
        if (s) begin
            r.gt = ($signed(av) > $signed(bv));
            r.lt = ($signed(av) < $signed(bv));
        end else begin
            r.gt = (av > bv);
            r.lt = (av < bv);
        end
        r.eq = (av == bv);
        diff = av ^ bv;
        p = -1;
        for (int i = 0; i < W; i++) if (diff[i]) p = i;
        r.cyc = (p < 0) ? N : N - p / C;
        r.acc_edge = 0;
        return r;
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Accept sampler: push the expected result for every handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && in_valid && in_ready) begin
            e = model(a, b, signed_mode);
            e.acc_edge = edge_cnt + 1;
            q.push_back(e);
        end
    end

    // Monitor: pops on each new result and checks hold/handshake behaviour.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_quiet", {28'd0, out_valid, eq, greater, lesser}, 32'd0);
            prev_valid = 1'b0;
            prev_taken = 1'b0;
        end else begin
            if (prev_taken) check("valid_falls", {31'd0, out_valid}, 32'd0);
            if (out_valid) begin
                check("onehot", 32'(eq) + 32'(greater) + 32'(lesser), 32'd1);
                if (!prev_valid) begin
                    if (q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        mon_e = q.pop_front();
                        check("eq", {31'd0, eq}, {31'd0, mon_e.eq});
                        check("greater", {31'd0, greater}, {31'd0, mon_e.gt});
                        check("lesser", {31'd0, lesser}, {31'd0, mon_e.lt});
                        check("cycles", 32'(cycles), 32'(mon_e.cyc));
                        check("latency", 32'(edge_cnt - mon_e.acc_edge), 32'(mon_e.cyc));
                    end
                    held = {25'd0, eq, greater, lesser, 32'(cycles)} & 32'h7F;
                    held = {25'd0, eq, greater, lesser, 4'(cycles)};
                end else if (!prev_taken) begin
                    check("hold", {25'd0, eq, greater, lesser, 4'(cycles)}, held);
                end
                if (!out_ready) check("in_ready_bp", {31'd0, in_ready}, 32'd0);
            end else begin
                check("flags_idle", {29'd0, eq, greater, lesser}, 32'd0);
            end
            prev_taken = out_valid && out_ready;
            prev_valid = out_valid;
        end
    end

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
        int   n;
        logic ok;
        in_valid = 1'b1; a = av; b = bv; signed_mode = s;
        n = 0; ok = 1'b0;
        do begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end while (!ok && n < 300);
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run4(input logic [3:0] av, input logic [3:0] bv, input logic s,
                        input logic [2:0] flags_exp, input string name);
        int n;
        in_valid4 = 1'b1; a4 = av; b4 = bv; signed_mode4 = s;
        n = 0;
        while (!in_ready4 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid4 && n < 50);
        check({name, "_valid"}, {31'd0, out_valid4}, 32'd1);
        check({name, "_flags"}, {29'd0, eq4, greater4, lesser4}, {29'd0, flags_exp});
        check({name, "_cycles"}, {31'd0, cycles4}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        check("watchdog", 32'd1, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [W-1:0] ra, rb;
        int k, n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; signed_mode = 1'b0;
        in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0; signed_mode4 = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("reset_state", {28'd0, out_valid, eq, greater, lesser}, 32'd0);
        check("reset_cycles", 32'(cycles), 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        send(16'h1234, 16'h1234, 1'b0);
        send(16'h8000, 16'h7FFF, 1'b0);
        send(16'h8000, 16'h7FFF, 1'b1);
        send(16'h1235, 16'h1234, 1'b0);
        send(16'hFFFF, 16'hFFFE, 1'b1);
        drain();

        // Backpressure, then back-to-back accept on the releasing edge.
        out_ready = 1'b0;
        send(16'hABCD, 16'hABCE, 1'b0);
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 50);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h0F00; b = 16'h0E00; signed_mode = 1'b0;
        @(posedge clk); #1;
        check("no_bubble_valid", {31'd0, out_valid}, 32'd0);
        check("no_bubble_run", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        drain();

        // Reset two cycles into RUN of an equal-operand compare.
        send(16'h5555, 16'h5555, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        #1;
        check("midrun_rst_out", {28'd0, out_valid, eq, greater, lesser}, 32'd0);
        check("midrun_rst_cycles", 32'(cycles), 32'd0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk); #1;
        send(16'h0001, 16'h0002, 1'b0);
        drain();

        // Randomised traffic with random consumer backpressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 80; t++) begin
            ra = 16'($urandom);
            k  = $urandom_range(0, 3);
            case (k)
                0:       rb = 16'($urandom);
                1:       rb = ra;
                2:       rb = ra ^ (16'd1 << $urandom_range(0, 15));
                default: rb = ra ^ 16'($urandom_range(0, 15));
            endcase
            send(ra, rb, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        run4(4'b1010, 4'b1010, 1'b0, 3'b100, "w4_eq");
        run4(4'b0001, 4'b1111, 1'b1, 3'b010, "w4_signed_gt");
        run4(4'b0001, 4'b1111, 1'b0, 3'b001, "w4_unsigned_lt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
